// File: rtl/ldst_top.sv
// ldst_top: load/store unit with local single-port RAM, operand latch and single/burst triggers
module ldst_single_ram #(
  parameter int DAT_W = 32,
  parameter int ADR_W = 7,
  parameter int DEPTH = 2 ** ADR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADR_W-1:0] addr,
  input  logic [DAT_W-1:0] wdat,
  output logic [DAT_W-1:0] rdat
);
  logic [DAT_W-1:0] mem [0:DEPTH-1];
  // one write per cycle; read is asynchronous and captured by the result register
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdat;
  end
  assign rdat = mem[addr];
endmodule

module ldst_top #(
  parameter int DAT_W = 32,
  parameter int ADR_W = 7,
  parameter int DEPTH = 2 ** ADR_W
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             ldst_o_sel,
  input  logic             ldst_t_sel,
  input  logic [4:0]       ldst_typ_sel,
  input  logic [DAT_W-1:0] ldst_o_dat,
  input  logic [DAT_W-1:0] ldst_t_dat,
  output logic [DAT_W-1:0] ldst_r_dat
);
  typedef enum logic [1:0] {IDLE, BLD, BST} mode_t;
  mode_t            mode_q, mode_d;
  logic [ADR_W-1:0] ptr_q, ptr_d, addr;
  logic [DAT_W-1:0] opr_q, opr_d, r_dat_q, r_dat_d, sdat, ram_rdat;
  logic             trig, cont, ss, sl, bs, bl, we, ld;
  logic             unused;
  assign unused = ^{ldst_t_dat[DAT_W-1:ADR_W], ldst_typ_sel[4]};
  ldst_single_ram #(.DAT_W(DAT_W), .ADR_W(ADR_W), .DEPTH(DEPTH)) Usingle_ram (
    .clk  (clk),
    .we   (we),
    .addr (addr),
    .wdat (sdat),
    .rdat (ram_rdat)
  );
  // decode trigger with store-before-load, single-before-burst priority and derive next state
  always_comb begin
    sdat    = ldst_o_sel ? ldst_o_dat : opr_q;
    trig    = ldst_t_sel && (ldst_typ_sel[3:0] != 4'd0);
    cont    = ldst_t_sel && (ldst_typ_sel == 5'd0) && (mode_q != IDLE);
    ss      = trig && ldst_typ_sel[1];
    sl      = trig && !ldst_typ_sel[1] && ldst_typ_sel[0];
    bs      = trig && (ldst_typ_sel[1:0] == 2'd0) && ldst_typ_sel[3];
    bl      = trig && (ldst_typ_sel[1:0] == 2'd0) && !ldst_typ_sel[3] && ldst_typ_sel[2];
    addr    = cont ? ptr_q : ldst_t_dat[ADR_W-1:0];
    we      = !rst_b && (ss || bs || (cont && mode_q == BST));
    ld      = sl || bl || (cont && mode_q == BLD);
    opr_d   = sdat;
    r_dat_d = ld ? ram_rdat : r_dat_q;
    mode_d  = (!ldst_t_sel || ss || sl) ? IDLE : bs ? BST : bl ? BLD : mode_q;
    ptr_d   = (bs || bl || cont) ? addr + 1'b1 : ptr_q;
  end
  // state registers; reset aborts any burst and clears the result
  always_ff @(posedge clk) begin
    if (rst_b) begin
      mode_q  <= IDLE;
      ptr_q   <= '0;
      opr_q   <= '0;
      r_dat_q <= '0;
    end else begin
      mode_q  <= mode_d;
      ptr_q   <= ptr_d;
      opr_q   <= opr_d;
      r_dat_q <= r_dat_d;
    end
  end
  assign ldst_r_dat = r_dat_q;
endmodule

// File: tb/tb_ldst_top.sv
// tb_ldst_top: directed self-checking bench for ldst_top
module tb_ldst_top;
  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        ldst_o_sel = 1'b0;
  logic        ldst_t_sel = 1'b0;
  logic [4:0]  ldst_typ_sel = 5'd0;
  logic [31:0] ldst_o_dat = '0;
  logic [31:0] ldst_t_dat = '0;
  logic [31:0] ldst_r_dat;
  int checks = 0;
  int fails = 0;

  ldst_top uut (
    .clk          (clk),
    .rst_b        (rst_b),
    .ldst_o_sel   (ldst_o_sel),
    .ldst_t_sel   (ldst_t_sel),
    .ldst_typ_sel (ldst_typ_sel),
    .ldst_o_dat   (ldst_o_dat),
    .ldst_t_dat   (ldst_t_dat),
    .ldst_r_dat   (ldst_r_dat)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ldst_t_sel = 1'b0;
    ldst_o_sel = 1'b0;
    ldst_typ_sel = 5'd0;
  endtask

  task automatic preload();
    rst_b = 1'b1;
    cyc();
    cyc();
    rst_b = 1'b0;
    ldst_o_sel = 1'b1;
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b01000;
    ldst_t_dat = 32'd0;
    ldst_o_dat = 32'h100;
    cyc();
    ldst_typ_sel = 5'd0;
    for (int k = 1; k < 128; k++) begin
      ldst_o_dat = 32'h100 + k;
      cyc();
    end
    idle();
    cyc();
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (ldst_r_dat !== 32'h0) begin
        fails++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, ldst_r_dat, 32'h0);
      end
    end
    rst_b = 1'b0;
  endtask

  task automatic test_single_load();
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b00001;
    ldst_t_dat = 32'd0;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h100) begin
      fails++;
      $display("FAIL single_load got=%h exp=%h", ldst_r_dat, 32'h100);
    end
    idle();
    cyc();
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h100) begin
      fails++;
      $display("FAIL load_hold got=%h exp=%h", ldst_r_dat, 32'h100);
    end
  endtask

  task automatic test_store();
    ldst_o_sel = 1'b1;
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b00010;
    ldst_t_dat = 32'd3;
    ldst_o_dat = 32'h0F0F0F0F;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h100) begin
      fails++;
      $display("FAIL store_rdat0 got=%h exp=%h", ldst_r_dat, 32'h100);
    end
    ldst_t_dat = 32'd4;
    ldst_o_dat = 32'h0F0F0F0E;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h100) begin
      fails++;
      $display("FAIL store_rdat1 got=%h exp=%h", ldst_r_dat, 32'h100);
    end
    idle();
    cyc();
  endtask

  task automatic test_burst_load();
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b00100;
    ldst_t_dat = 32'd3;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h0F0F0F0F) begin
      fails++;
      $display("FAIL bload0 got=%h exp=%h", ldst_r_dat, 32'h0F0F0F0F);
    end
    ldst_typ_sel = 5'd0;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h0F0F0F0E) begin
      fails++;
      $display("FAIL bload1 got=%h exp=%h", ldst_r_dat, 32'h0F0F0F0E);
    end
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h105) begin
      fails++;
      $display("FAIL bload2 got=%h exp=%h", ldst_r_dat, 32'h105);
    end
    ldst_t_sel = 1'b0;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h105) begin
      fails++;
      $display("FAIL bload_stop got=%h exp=%h", ldst_r_dat, 32'h105);
    end
    ldst_t_sel = 1'b1;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h105) begin
      fails++;
      $display("FAIL bload_ended got=%h exp=%h", ldst_r_dat, 32'h105);
    end
    idle();
    cyc();
  endtask

  task automatic test_burst_store_wrap();
    ldst_o_sel = 1'b1;
    ldst_o_dat = 32'hDEADBEEF;
    cyc();
    ldst_o_sel = 1'b0;
    ldst_o_dat = 32'h0;
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b01000;
    ldst_t_dat = 32'hFFFFFF7F;
    cyc();
    ldst_typ_sel = 5'd0;
    cyc();
    idle();
    cyc();
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b00001;
    ldst_t_dat = 32'd127;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wrap_mem127 got=%h exp=%h", ldst_r_dat, 32'hDEADBEEF);
    end
    ldst_t_dat = 32'd0;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wrap_mem0 got=%h exp=%h", ldst_r_dat, 32'hDEADBEEF);
    end
    ldst_t_dat = 32'd1;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h101) begin
      fails++;
      $display("FAIL wrap_mem1 got=%h exp=%h", ldst_r_dat, 32'h101);
    end
    idle();
    cyc();
  endtask

  task automatic test_priority();
    ldst_o_sel = 1'b1;
    ldst_o_dat = 32'h1;
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b00011;
    ldst_t_dat = 32'd5;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h101) begin
      fails++;
      $display("FAIL prio_rdat got=%h exp=%h", ldst_r_dat, 32'h101);
    end
    ldst_o_sel = 1'b0;
    ldst_typ_sel = 5'b00001;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h1) begin
      fails++;
      $display("FAIL prio_mem5 got=%h exp=%h", ldst_r_dat, 32'h1);
    end
    ldst_typ_sel = 5'b10000;
    ldst_t_dat = 32'd7;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h1) begin
      fails++;
      $display("FAIL typ_bit4_noop got=%h exp=%h", ldst_r_dat, 32'h1);
    end
    idle();
    cyc();
  endtask

  task automatic test_burst_store_bypass();
    ldst_o_sel = 1'b1;
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b01000;
    ldst_t_dat = 32'd40;
    for (int i = 0; i < 3; i++) begin
      ldst_o_dat = 32'hA0 + i;
      cyc();
      ldst_typ_sel = 5'd0;
    end
    idle();
    cyc();
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b00100;
    ldst_t_dat = 32'd40;
    for (int i = 0; i < 3; i++) begin
      cyc();
      ldst_typ_sel = 5'd0;
      checks++;
      if (ldst_r_dat !== 32'hA0 + i) begin
        fails++;
        $display("FAIL bstore_bypass%0d got=%h exp=%h", i, ldst_r_dat, 32'hA0 + i);
      end
    end
    idle();
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b00100;
    ldst_t_dat = 32'd6;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h106) begin
      fails++;
      $display("FAIL mid_burst0 got=%h exp=%h", ldst_r_dat, 32'h106);
    end
    ldst_typ_sel = 5'd0;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h107) begin
      fails++;
      $display("FAIL mid_burst1 got=%h exp=%h", ldst_r_dat, 32'h107);
    end
    rst_b = 1'b1;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h0) begin
      fails++;
      $display("FAIL mid_burst_rst got=%h exp=%h", ldst_r_dat, 32'h0);
    end
    rst_b = 1'b0;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h0) begin
      fails++;
      $display("FAIL after_rst_noop got=%h exp=%h", ldst_r_dat, 32'h0);
    end
    rst_b = 1'b1;
    ldst_o_sel = 1'b1;
    ldst_o_dat = 32'hBAD;
    ldst_typ_sel = 5'b00010;
    ldst_t_dat = 32'd9;
    cyc();
    rst_b = 1'b0;
    ldst_o_sel = 1'b0;
    ldst_typ_sel = 5'b00001;
    cyc();
    checks++;
    if (ldst_r_dat !== 32'h109) begin
      fails++;
      $display("FAIL rst_blocks_write got=%h exp=%h", ldst_r_dat, 32'h109);
    end
    idle();
    cyc();
  endtask

  task automatic test_back_to_back();
    ldst_t_sel = 1'b1;
    ldst_typ_sel = 5'b00001;
    for (int i = 1; i <= 3; i++) begin
      ldst_t_dat = 32'd10 * i;
      cyc();
      checks++;
      if (ldst_r_dat !== 32'h100 + 10 * i) begin
        fails++;
        $display("FAIL b2b_load%0d got=%h exp=%h", i, ldst_r_dat, 32'h100 + 10 * i);
      end
    end
    idle();
    cyc();
  endtask

  initial begin
    preload();
    test_reset();
    test_single_load();
    test_store();
    test_burst_load();
    test_burst_store_wrap();
    test_priority();
    test_burst_store_bypass();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ldst_top.md
Name: ldst_top

Overview:
- Load/store functional unit of the Niederreiter cryptoprocessor ASIP (transport-triggered style).
- Holds a local single-port data RAM, 128 x 32-bit.
- An operand port latches store data; a trigger port supplies the address and starts a single or burst load/store.
- Load results are presented on a registered result port read by the interconnect.

Parameters:
- DAT_W, 32, data word width (matches `DAT_W).
- ADR_W, 7, RAM address width, taken from ldst_t_dat[ADR_W-1:0].
- DEPTH, 128, RAM words (2**ADR_W).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_b  in  1  reset, synchronous, active-high.
- ldst_o_sel  in  1  store-operand write strobe.
- ldst_t_sel  in  1  trigger strobe.
- ldst_typ_sel  in  5  operation type: bit0 single load, bit1 single store, bit2 burst load, bit3 burst store, bit4 reserved (ignored).
- ldst_o_dat  in  DAT_W  store operand data.
- ldst_t_dat  in  DAT_W  trigger data; low ADR_W bits = RAM address, upper bits ignored.
- ldst_r_dat  out  DAT_W  load result (registered).

Behaviour:
- RAM: instance named Usingle_ram, with storage array named mem[0:DEPTH-1] of DAT_W bits. Not cleared by reset; benches preload it via $readmemh on uut.Usingle_ram.mem. One access per cycle (single port).
- Operand register (opr):
  - Loads ldst_o_dat when ldst_o_sel=1.
  - Bypass: if ldst_o_sel=1 in the trigger cycle, the write uses the current ldst_o_dat.
- Trigger decode, evaluated when ldst_t_sel=1 and typ != 0. Priority: bit1 > bit0 > bit3 > bit2.
  - Single store: mem[addr] <= store data at this edge. Burst state cleared. ldst_r_dat unchanged.
  - Single load: RAM read at addr. ldst_r_dat = mem[addr] after the next rising edge (1-cycle latency). Held until the next load. Burst state cleared.
  - Burst load: as single load at addr. Burst-load mode entered; burst pointer = addr+1.
  - Burst store: as single store at addr. Burst-store mode entered; burst pointer = addr+1.
- Burst continuation: in a burst mode, each cycle with ldst_t_sel=1 and typ=00000 performs the same operation at the burst pointer, then increments the pointer.
  - Burst store writes the current store data (opr or bypass).
  - Loads keep 1-cycle latency, so consecutive words stream one per cycle.
- Burst termination: ldst_t_sel=0 ends the burst (mode cleared). A new non-zero typ with t_sel=1 replaces it per the decode rules.
- Wrap-around: pointer and address arithmetic are mod DEPTH (127 -> 0).
- Idle: ldst_t_sel=0, or t_sel=1 with typ=0 and no burst active, is a no-op. ldst_r_dat holds.
- typ=10000 (bit4 only) is a no-op.
- Reset (rst_b=1 at an edge): ldst_r_dat=0, opr=0, burst mode cleared, pointer=0.
  - Reset wins over any simultaneous trigger; no RAM write occurs that cycle.
  - Reset mid-burst aborts the burst.
- No back-pressure or handshake; the unit accepts a trigger every cycle.

Test Plan:
- Preload mem[k]=0x100+k. Reset asserted 10 cycles, ldst_r_dat=0 throughout. Then t_sel=1, typ=00001, t_dat=0 -> ldst_r_dat=0x00000100 one cycle later, held after t_sel drops.
- Store: o_sel=1, t_sel=1, typ=00010, t_dat=3, o_dat=0x0F0F0F0F; next cycle t_dat=4, o_dat=0x0F0F0F0E -> mem[3]=0x0F0F0F0F, mem[4]=0x0F0F0F0E; ldst_r_dat unchanged.
- Burst load: typ=00100, t_dat=3, then t_sel=1, typ=0 for 2 more cycles -> ldst_r_dat sequence 0x0F0F0F0F, 0x0F0F0F0E, 0x00000105 on consecutive cycles. t_sel=0 stops the burst and r_dat holds.
- Burst store wrap: opr=0xDEADBEEF, typ=01000, t_dat=127, then 1 continuation cycle -> mem[127] and mem[0] = 0xDEADBEEF.
- Priority/reset: typ=00011 at addr 5 with o_dat=0x1 -> store only (mem[5]=1, r_dat unchanged). rst_b=1 during an active burst -> r_dat=0 and a following typ=0 trigger performs no access.
